multicycle_control: RTL

//  Main control FSM for the multicycle MIPS datapath. Sequences fetch/decode/execute for R-type, LW, SW, BEQ, J
//  and drives the mux selects, write enables and the 2-bit ALUOp consumed by the ALU control decoder.

---
 rtl/multicycle_control_pkg.sv | 63 ++++++
 rtl/multicycle_control_output_decoder.sv | 84 ++++++++
 rtl/multicycle_control.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings, opcodes,
// ALUOp codes and the control-word layout. Also imported by ALU control and the datapath.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // States that stall on the memory handshake and are covered by the timeout.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_output_decoder.sv
// Combinational State -> control word for the multicycle control FSM.
// ADDI states decode only when MC_ADDI_EN is defined.
module mc_output_decoder
  import multicycle_control_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_NONE;
    unique case (i_state)
      S_FETCH: begin
        // ir_write/pc_write are qualified by MemReady in the top
        o_ctrl.iord      = 1'b0;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMMSH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = 1'b0;
        o_ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.pc_write  = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        o_ctrl.reg_dst    = 1'b0;
        o_ctrl.mem_to_reg = 1'b0;
        o_ctrl.reg_write  = 1'b1;
      end
`endif
      default: o_ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath with memory-ready timeout.
// Define MC_ADDI_EN to add the ADDI execute/write-back states.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       MemErr,
  output logic       IllegalOp,
  output logic [3:0] State
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC+4; waits on MemReady
  // DECODE | register read, branch target into ALUOut, dispatch on opcode
  // MEMADR | load/store address = A + SignImm
  // MEMRD  | data read at ALUOut; waits on MemReady
  // MEMWB  | MDR -> rt
  // MEMWR  | data write at ALUOut; waits on MemReady
  // EXEC   | R-type ALU operation
  // ALUWB  | ALUOut -> rd
  // BRANCH | A - B, PC <= ALUOut if Zero
  // JUMP   | PC <= jump target
  // ADDIEX | A + SignImm (MC_ADDI_EN)
  // ADDIWB | ALUOut -> rt (MC_ADDI_EN)

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_err;
  logic              r_illegal;
  logic              w_waiting;
  logic              w_timeout;
  logic              w_illegal;
  logic              w_run;
  logic              w_fetch_ok;
  ctrl_t             w_ctrl;

  assign w_waiting = is_mem_wait(r_state) && !MemReady;
  assign w_timeout = w_waiting && (r_wait == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    unique case (r_state)
      S_FETCH:  if (MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      w_next = S_ADDIEX;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (MemReady) w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
`endif
      default:  w_next = S_FETCH;
    endcase
    // an expired wait overrides the hold; MemReady in the same cycle keeps w_timeout low
    if (w_timeout) begin
      w_next = S_FETCH;
    end
  end

  // A FETCH timeout does not change state, so the counter is also cleared on abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if ((w_next != r_state) || w_timeout) begin
      r_wait <= '0;
    end else if (w_waiting) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
      r_illegal <= w_illegal;
    end
  end

  mc_output_decoder u_output_decoder (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Reset forces the whole control word to zero, so FETCH strobes cannot leak out.
  assign w_run      = ~reset;
  assign w_fetch_ok = (r_state != S_FETCH) || MemReady;

  assign PCWrite     = w_run & w_ctrl.pc_write & w_fetch_ok;
  assign IRWrite     = w_run & w_ctrl.ir_write & MemReady;
  assign PCWriteCond = w_run & w_ctrl.pc_write_cond;
  assign IorD        = w_run & w_ctrl.iord;
  assign MemRead     = w_run & w_ctrl.mem_read;
  assign MemWrite    = w_run & w_ctrl.mem_write;
  assign MemtoReg    = w_run & w_ctrl.mem_to_reg;
  assign RegDst      = w_run & w_ctrl.reg_dst;
  assign RegWrite    = w_run & w_ctrl.reg_write;
  assign ALUSrcA     = w_run & w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b & {2{w_run}};
  assign ALUOp       = w_ctrl.alu_op & {2{w_run}};
  assign PCSource    = w_ctrl.pc_source & {2{w_run}};
  assign MemErr      = r_mem_err;
  assign IllegalOp   = r_illegal;
  assign State       = r_state;

endmodule
